// File: rtl/ray_hit_collector_if.sv
// Comparator-issue / verdict bundle for the ray-box hit collector.
// The master side issues comparisons and supplies le. The slave side reports verdicts.
interface ray_hit_collector_if #(
    parameter int ID_W = 8
);
    logic            in_valid;
    logic            in_last;
    logic [ID_W-1:0] in_id;
    logic            le;
    logic            hit_valid;
    logic            hit;
    logic [ID_W-1:0] hit_id;
    logic            err;

    modport master (
        output in_valid, in_last, in_id, le,
        input  hit_valid, hit, hit_id, err
    );

    modport slave (
        input  in_valid, in_last, in_id, le,
        output hit_valid, hit, hit_id, err
    );
endinterface

// File: rtl/ray_hit_collector.sv
// Folds the per-axis comparator results (tnear_max <= tfar_min) of each ray into one hit verdict.
// The issue tags are delayed so that they line up with the comparator output.
module ray_hit_collector #(
    parameter int CMP_LAT = 4,
    parameter int NCMP    = 3,
    parameter int ID_W    = 8
) (
    input logic              clk,
    input logic              rst,
    ray_hit_collector_if.slave bus
);
    localparam int                 CNT_W    = $clog2(NCMP + 2);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(NCMP + 1);
    localparam logic [CNT_W:0]     NCMP_EXT = (CNT_W + 1)'(NCMP);

    typedef enum logic {
        S_IDLE,
        S_OPEN
    } state_t;

    logic            d_valid;
    logic            d_last;
    logic [ID_W-1:0] d_id;

    // Tag pipeline: the last stage coincides with the comparator's le for the same issue.
    genvar gi;
    generate
        for (gi = 0; gi < CMP_LAT; gi++) begin : g_stage
            logic            valid_reg;
            logic            last_reg;
            logic [ID_W-1:0] id_reg;
            logic            valid_in;
            logic            last_in;
            logic [ID_W-1:0] id_in;

            if (gi == 0) begin : g_head
                assign valid_in = bus.in_valid;
                assign last_in  = bus.in_last;
                assign id_in    = bus.in_id;
            end else begin : g_tail
                assign valid_in = g_stage[gi-1].valid_reg;
                assign last_in  = g_stage[gi-1].last_reg;
                assign id_in    = g_stage[gi-1].id_reg;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                    id_reg    <= '0;
                end else begin
                    valid_reg <= valid_in;
                    last_reg  <= valid_in & last_in;
                    id_reg    <= id_in;
                end
            end
        end
    endgenerate

    assign d_valid = g_stage[CMP_LAT-1].valid_reg;
    assign d_last  = g_stage[CMP_LAT-1].last_reg;
    assign d_id    = g_stage[CMP_LAT-1].id_reg;

    state_t          state_reg, state_next;
    logic            acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [ID_W-1:0] cur_id_reg, cur_id_next;
    logic            mismatch_reg, mismatch_next;
    logic            hit_valid_reg, hit_valid_next;
    logic            hit_reg, hit_next;
    logic [ID_W-1:0] hit_id_reg, hit_id_next;
    logic            err_reg, err_next;

    logic            id_diff;
    logic            count_bad;
    logic            err_cond;
    logic [CNT_W-1:0] cnt_inc;

    // Saturate so that an overlong ray can never wrap back to a legal count.
    assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    assign id_diff   = (state_reg == S_OPEN) && (d_id != cur_id_reg);
    assign count_bad = (({1'b0, cnt_reg} + 1'b1) != NCMP_EXT);
    assign err_cond  = mismatch_reg | id_diff | count_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            acc_reg       <= 1'b1;
            cnt_reg       <= '0;
            cur_id_reg    <= '0;
            mismatch_reg  <= 1'b0;
            hit_valid_reg <= 1'b0;
            hit_reg       <= 1'b0;
            hit_id_reg    <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            cur_id_reg    <= cur_id_next;
            mismatch_reg  <= mismatch_next;
            hit_valid_reg <= hit_valid_next;
            hit_reg       <= hit_next;
            hit_id_reg    <= hit_id_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        cur_id_next    = cur_id_reg;
        mismatch_next  = mismatch_reg;
        hit_valid_next = 1'b0;
        hit_next       = hit_reg;
        hit_id_next    = hit_id_reg;
        err_next       = err_reg;

        if (d_valid) begin
            if (!d_last) begin
                acc_next = acc_reg & bus.le;
                cnt_next = cnt_inc;
                if (state_reg == S_IDLE) begin
                    cur_id_next = d_id;
                    state_next  = S_OPEN;
                end else if (id_diff) begin
                    mismatch_next = 1'b1;
                end
            end else begin
                // Verdict cycle: the accumulator is re-armed here so the next ray may follow without a bubble.
                hit_valid_next = 1'b1;
                hit_next       = acc_reg & bus.le & ~err_cond;
                hit_id_next    = (state_reg == S_OPEN) ? cur_id_reg : d_id;
                err_next       = err_cond;
                acc_next       = 1'b1;
                cnt_next       = '0;
                mismatch_next  = 1'b0;
                state_next     = S_IDLE;
            end
        end
    end

    assign bus.hit_valid = hit_valid_reg;
    assign bus.hit       = hit_reg;
    assign bus.hit_id    = hit_id_reg;
    assign bus.err       = err_reg;
endmodule
